// File: rtl/fp_term_pkg.sv
// fp_term_pkg: shared FP32 constants, result record, rounding helper and multiplier.
// Provides field widths, bias, QNAN/POS_INF, default TERM_LAT, fp_round and fp_mul.
package fp_term_pkg;
    localparam int SW = 1;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam int TERM_LAT_DEF = 15;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } fp_res_t;

    // m carries the hidden bit in m[23]; e is the unbiased-plus-bias exponent before rounding
    function automatic fp_res_t fp_round(input logic sign, input int e, input logic [23:0] m,
                                         input logic g, input logic st);
        logic [24:0] r;
        int ex;
        r = {1'b0, m} + 25'(g & (st | m[0]));
        ex = e + int'(r[24]);
        if (ex >= 255) return fp_res_t'{{sign, 8'hFF, 23'h0}, 1'b1, 1'b0};
        if (ex <= 0) return fp_res_t'{{sign, 31'h0}, 1'b0, 1'b1};
        return fp_res_t'{{sign, 8'(ex), r[24] ? r[23:1] : r[22:0]}, 1'b0, 1'b0};
    endfunction

    // Subnormal operands are read as zero; results below the normal range flush to zero
    function automatic fp_res_t fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic sign, an, bn, ai, bi, az, bz;
        int e;
        sign = a[31] ^ b[31];
        an = (&a[30:23]) && (|a[22:0]);
        bn = (&b[30:23]) && (|b[22:0]);
        ai = (&a[30:23]) && !(|a[22:0]);
        bi = (&b[30:23]) && !(|b[22:0]);
        az = a[30:23] == 8'h0;
        bz = b[30:23] == 8'h0;
        if (an || bn || (ai && bz) || (bi && az)) return fp_res_t'{QNAN, 1'b0, 1'b0};
        if (ai || bi) return fp_res_t'{{sign, 8'hFF, 23'h0}, 1'b0, 1'b0};
        if (az || bz) return fp_res_t'{{sign, 31'h0}, 1'b0, 1'b0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - BIAS + int'(p[47]);
        return p[47] ? fp_round(sign, e, p[47:24], p[23], |p[22:0])
                     : fp_round(sign, e, p[46:23], p[22], |p[21:0]);
    endfunction
endpackage

// File: rtl/fp_add.sv
// fp_add: combinational FP32 adder, round-to-nearest-even, subnormals read/flushed as zero.
// Ports: a, b (FP32 in), result (FP32 out), ovf (finite operands overflowed), unf (nonzero flushed).
module fp_add
    import fp_term_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);
    function automatic fp_res_t add(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] l, s;
        logic [56:0] ma, mb, sm;
        logic pn, qn, pi, qi, pz, qz;
        int d, msb;
        pn = (&p[30:23]) && (|p[22:0]);
        qn = (&q[30:23]) && (|q[22:0]);
        pi = (&p[30:23]) && !(|p[22:0]);
        qi = (&q[30:23]) && !(|q[22:0]);
        pz = p[30:23] == 8'h0;
        qz = q[30:23] == 8'h0;
        if (pn || qn || (pi && qi && (p[31] != q[31]))) return fp_res_t'{QNAN, 1'b0, 1'b0};
        if (pi) return fp_res_t'{p, 1'b0, 1'b0};
        if (qi) return fp_res_t'{q, 1'b0, 1'b0};
        if (pz && qz) return fp_res_t'{{p[31] & q[31], 31'h0}, 1'b0, 1'b0};
        if (pz) return fp_res_t'{q, 1'b0, 1'b0};
        if (qz) return fp_res_t'{p, 1'b0, 1'b0};
        l = (q[30:0] > p[30:0]) ? q : p;
        s = (q[30:0] > p[30:0]) ? p : q;
        d = int'(l[30:23]) - int'(s[30:23]);
        ma = {1'b0, 1'b1, l[22:0], 32'h0};
        // Beyond 25 places the smaller operand lies wholly below the round bit; a lone
        // sticky LSB then produces the same guard/round/sticky pattern for add and subtract.
        mb = (d >= 26) ? 57'd1 : ({1'b0, 1'b1, s[22:0], 32'h0} >> d);
        sm = (l[31] == s[31]) ? ma + mb : ma - mb;
        if (sm == 57'd0) return fp_res_t'{32'h0, 1'b0, 1'b0};
        msb = 0;
        for (int i = 0; i < 57; i++) if (sm[i]) msb = i;
        sm = sm << (56 - msb);
        return fp_round(l[31], int'(l[30:23]) + msb - 55, sm[56:33], sm[32], |sm[31:0]);
    endfunction

    assign {result, ovf, unf} = add(a, b);
endmodule

// File: rtl/fp_term_acc.sv
// fp_term_acc: pipelined FP32 term y = 0.5*x + x^3 feeding a running-sum accumulator.
// Ports: clk, reset (sync, active-high), in_valid/x (sample in), clear (restart sum),
// sum/sum_valid (running sum and update pulse), xo/xu (sticky term ovf/unf), ao (sticky acc ovf).
module fp_term_acc
    import fp_term_pkg::*;
#(
    parameter int TERM_LAT = TERM_LAT_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] x,
    input  logic        clear,
    output logic [31:0] sum,
    output logic        sum_valid,
    output logic        xo,
    output logic        xu,
    output logic        ao
);
    localparam int W = 34 * TERM_LAT;

    logic [31:0] x_r, y, ty, acc_n;
    logic [W-1:0] td;
    logic [TERM_LAT:0] v;
    logic y_ovf, y_unf, t_xo, t_xu, txo, txu, arr, st, first, a_ovf, unused_acc_unf;
    fp_res_t h, s, c;

    // h is an exact halving through the multiplier, which also handles flush and specials
    assign h = fp_mul(x_r, 32'h3F000000);
    assign s = fp_mul(x_r, x_r);
    assign c = fp_mul(s.res, x_r);

    fp_add u_term (.a(h.res), .b(c.res), .result(y), .ovf(y_ovf), .unf(y_unf));

    assign t_xo = c.ovf | y_ovf;
    assign t_xu = h.unf | s.unf | c.unf | y_unf;
    assign {ty, txo, txu} = td[W-1 -: 34];
    assign arr = v[TERM_LAT];
    // A clear arriving with a term makes that term the start of the new sum
    assign st = first | clear;

    fp_add u_acc (.a(sum), .b(ty), .result(acc_n), .ovf(a_ovf), .unf(unused_acc_unf));

    always_ff @(posedge clk) begin
        x_r <= x;
        td <= W'({td, y, t_xo, t_xu});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            sum <= 32'h0;
            sum_valid <= 1'b0;
            xo <= 1'b0;
            xu <= 1'b0;
            ao <= 1'b0;
            first <= 1'b1;
        end else begin
            v <= {v[TERM_LAT-1:0], in_valid};
            sum_valid <= arr;
            if (arr) begin
                sum <= st ? ty : acc_n;
                first <= 1'b0;
                xo <= (xo & ~clear) | txo;
                xu <= (xu & ~clear) | txu;
                ao <= (ao & ~clear) | (~st & a_ovf);
            end else if (clear) begin
                first <= 1'b1;
                xo <= 1'b0;
                xu <= 1'b0;
                ao <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_term_acc.sv
// tb_fp_term_acc: directed self-checking bench for fp_term_acc with hand-computed expectations.
module tb_fp_term_acc;
    logic clk = 1'b0;
    logic reset, in_valid, clear;
    logic [31:0] x, sum;
    logic sum_valid, xo, xu, ao;
    int n = 0;
    int bad = 0;
    int pulses;

    always #5 clk = ~clk;

    fp_term_acc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
        .sum(sum), .sum_valid(sum_valid), .xo(xo), .xu(xu), .ao(ao)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] val, input logic clr);
        in_valid = 1'b1;
        x = val;
        clear = clr;
        step();
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_sv(input string tag);
        int t = 0;
        while (!sum_valid && t < 40) begin
            step();
            t++;
        end
        chk({tag, "_valid"}, 32'(sum_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; x = 32'h0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_sum", sum, 32'h0);
        chk("rst_valid", 32'(sum_valid), 32'd0);
        chk("rst_flags", 32'({xo, xu, ao}), 32'd0);

        clear = 1'b1; step(); clear = 1'b0;
        in_valid = 1'b1; x = 32'h3F800000; step();
        x = 32'h40000000; step();
        in_valid = 1'b0;
        repeat (14) step();
        chk("lat_early", 32'(sum_valid), 32'd0);
        step();
        chk("sum1", sum, 32'h3FC00000);
        chk("sum1_valid", 32'(sum_valid), 32'd1);
        chk("sum1_flags", 32'({xo, xu, ao}), 32'd0);
        step();
        chk("sum2", sum, 32'h41280000);
        chk("sum2_valid", 32'(sum_valid), 32'd1);
        step();
        chk("pulse_end", 32'(sum_valid), 32'd0);

        send(32'hBF800000, 1'b0);
        repeat (15) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("restart_sum", sum, 32'hBFC00000);
        chk("restart_valid", 32'(sum_valid), 32'd1);

        send(32'h551184E7, 1'b1);
        wait_sv("tovf");
        chk("tovf_sum", sum, 32'h7F800000);
        chk("tovf_xo", 32'(xo), 32'd1);
        chk("tovf_ao", 32'(ao), 32'd0);
        chk("tovf_xu", 32'(xu), 32'd0);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_xo", 32'(xo), 32'd0);
        chk("clr_sum_kept", sum, 32'h7F800000);

        in_valid = 1'b1; x = 32'h54800000;
        repeat (4) step();
        in_valid = 1'b0;
        wait_sv("acc");
        chk("acc1", sum, 32'h7E800000);
        chk("acc1_ao", 32'(ao), 32'd0);
        step();
        chk("acc2", sum, 32'h7F000000);
        chk("acc2_ao", 32'(ao), 32'd0);
        step();
        chk("acc3", sum, 32'h7F400000);
        chk("acc3_ao", 32'(ao), 32'd0);
        step();
        chk("acc4", sum, 32'h7F800000);
        chk("acc4_ao", 32'(ao), 32'd1);
        chk("acc4_xo", 32'(xo), 32'd0);

        send(32'h7FC00000, 1'b1);
        wait_sv("nan");
        chk("nan_sum", sum, 32'h7FC00000);
        send(32'h00000001, 1'b1);
        wait_sv("sub");
        chk("sub_sum", sum, 32'h0);
        chk("sub_xu", 32'(xu), 32'd0);
        send(32'h1F800000, 1'b1);
        wait_sv("unf");
        chk("unf_sum", sum, 32'h1F000000);
        chk("unf_xu", 32'(xu), 32'd1);

        send(32'h3F800000, 1'b0);
        repeat (4) step();
        reset = 1'b1; step(); reset = 1'b0;
        pulses = 0;
        repeat (30) begin
            step();
            if (sum_valid) pulses++;
        end
        chk("midrst_pulses", 32'(pulses), 32'd0);
        chk("midrst_sum", sum, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n, bad);
        $finish;
    end
endmodule
